// File: rtl/frac_pkg.sv
// frac_pkg: FSM state encoding and sizing constants shared by the frac_search feeder files
package frac_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, STREAM, WAIT, DONE} state_t;
  localparam int BLK_ROWS = 8;
  localparam int STREAM_STEPS = 9;
  localparam int PIX_W = 8;
  localparam int SAD_W = 12;
  localparam int MV_W = 3;
  localparam int ADDR_W = $clog2(BLK_ROWS);
  localparam int ROW_W = PIX_W * BLK_ROWS;
  localparam int ORG_W = PIX_W * 6;
endpackage

// File: rtl/frac_search_feeder_if.sv
// frac_search_feeder_if: start/row-memory/frac_search/result bundle; master = feeder, slave = environment; min_* exist only with FRAC_FEEDER_MINSAD_EN
interface frac_search_feeder_if;
  import frac_pkg::*;
  logic start;
  logic [ADDR_W-1:0] cur_addr, org_addr;
  logic [ROW_W-1:0] cur_rdata, cur_pix;
  logic [ORG_W-1:0] org_rdata, org_pix;
  logic ready, busy, result_valid;
  logic [SAD_W-1:0] sad_in, sad;
  logic [MV_W-1:0] mvx_in, mvy_in, mvx, mvy;
`ifdef FRAC_FEEDER_MINSAD_EN
  logic [SAD_W-1:0] min_sad;
  logic [MV_W-1:0] min_mvx, min_mvy;
  modport master (input start, cur_rdata, org_rdata, sad_in, mvx_in, mvy_in,
                  output cur_addr, org_addr, cur_pix, org_pix, ready, busy, result_valid, sad, mvx, mvy,
                  min_sad, min_mvx, min_mvy);
  modport slave (output start, cur_rdata, org_rdata, sad_in, mvx_in, mvy_in,
                 input cur_addr, org_addr, cur_pix, org_pix, ready, busy, result_valid, sad, mvx, mvy,
                 min_sad, min_mvx, min_mvy);
`else
  modport master (input start, cur_rdata, org_rdata, sad_in, mvx_in, mvy_in,
                  output cur_addr, org_addr, cur_pix, org_pix, ready, busy, result_valid, sad, mvx, mvy);
  modport slave (output start, cur_rdata, org_rdata, sad_in, mvx_in, mvy_in,
                 input cur_addr, org_addr, cur_pix, org_pix, ready, busy, result_valid, sad, mvx, mvy);
`endif
endinterface

// File: rtl/frac_search_feeder.sv
// frac_search_feeder: streams an 8x8 block plus reference rows into frac_search over bus (clk, sync active-high reset), captures SAD/MV; FRAC_FEEDER_MINSAD_EN adds running minimum
module frac_search_feeder
  import frac_pkg::*;
#(
  parameter int RESULT_LAT = 1
) (
  input logic clk,
  input logic reset,
  frac_search_feeder_if.master bus
);
  localparam logic [3:0] LAST = 4'(STREAM_STEPS - 1);
  localparam logic [3:0] LAT = 4'(RESULT_LAT);
  localparam logic [3:0] TOP = 4'(BLK_ROWS - 1);
  state_t state_q, state_d;
  logic [3:0] j_q, j_d, cur_nxt, org_nxt;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, org_addr_q, org_addr_d;
  logic [ROW_W-1:0] cur_pix_q, cur_pix_d;
  logic [ORG_W-1:0] org_pix_q, org_pix_d;
  logic ready_q, busy_q, valid_q;
  logic [SAD_W-1:0] sad_q;
  logic [MV_W-1:0] mvx_q, mvy_q;
  always_comb begin
    state_d = state_q;
    j_d = j_q;
    case (state_q)
      IDLE: state_d = bus.start ? FETCH : IDLE;
      FETCH: begin
        state_d = STREAM;
        j_d = '0;
      end
      STREAM: begin
        state_d = j_q == LAST ? (LAT == 4'd0 ? DONE : WAIT) : STREAM;
        j_d = j_q == LAST ? 4'd1 : j_q + 4'd1;
      end
      WAIT: begin
        state_d = j_q >= LAT ? DONE : WAIT;
        j_d = j_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // Address registers lead the pixel registers by two cycles (address -> memory -> pixel flop)
    cur_nxt = j_d + 4'd2;
    org_nxt = j_d + 4'd1;
    cur_addr_d = state_d == FETCH ? ADDR_W'(1) :
                 state_d == STREAM ? ADDR_W'(cur_nxt > TOP ? TOP : cur_nxt) : '0;
    org_addr_d = state_d == STREAM ? ADDR_W'(org_nxt > TOP ? TOP : org_nxt) : '0;
    cur_pix_d = (state_q == FETCH || (state_q == STREAM && j_q < TOP)) ? bus.cur_rdata :
                (state_q == STREAM && j_q == TOP) ? cur_pix_q : '0;
    org_pix_d = (state_q == STREAM && j_q < LAST) ? bus.org_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      j_q <= '0;
      cur_addr_q <= '0;
      org_addr_q <= '0;
      cur_pix_q <= '0;
      org_pix_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      sad_q <= '0;
      mvx_q <= '0;
      mvy_q <= '0;
    end else begin
      state_q <= state_d;
      j_q <= j_d;
      cur_addr_q <= cur_addr_d;
      org_addr_q <= org_addr_d;
      cur_pix_q <= cur_pix_d;
      org_pix_q <= org_pix_d;
      ready_q <= state_d == STREAM;
      busy_q <= state_d inside {FETCH, STREAM, WAIT};
      valid_q <= state_d == DONE;
      if (state_q == DONE) begin
        sad_q <= bus.sad_in;
        mvx_q <= bus.mvx_in;
        mvy_q <= bus.mvy_in;
      end
    end
  end
`ifdef FRAC_FEEDER_MINSAD_EN
  logic [SAD_W-1:0] min_sad_q;
  logic [MV_W-1:0] min_mvx_q, min_mvy_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      min_sad_q <= '1;
      min_mvx_q <= '0;
      min_mvy_q <= '0;
    end else if (state_q == DONE && bus.sad_in < min_sad_q) begin
      min_sad_q <= bus.sad_in;
      min_mvx_q <= bus.mvx_in;
      min_mvy_q <= bus.mvy_in;
    end
  end
  assign bus.min_sad = min_sad_q;
  assign bus.min_mvx = min_mvx_q;
  assign bus.min_mvy = min_mvy_q;
`endif
  assign bus.cur_addr = cur_addr_q;
  assign bus.org_addr = org_addr_q;
  assign bus.cur_pix = cur_pix_q;
  assign bus.org_pix = org_pix_q;
  assign bus.ready = ready_q;
  assign bus.busy = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.sad = sad_q;
  assign bus.mvx = mvx_q;
  assign bus.mvy = mvy_q;
endmodule

// File: tb/tb_frac_search_feeder.sv
// tb_frac_search_feeder: table vectors, random blocks against a row-memory model, and multi-cycle corner sequences
module tb_frac_search_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  frac_search_feeder_if b1();
  frac_search_feeder_if b3();
  frac_search_feeder #(.RESULT_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  frac_search_feeder #(.RESULT_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));
  always #5 clk = ~clk;
  logic [63:0] cur_mem [8];
  logic [47:0] org_mem [8];
  always @(posedge clk) begin
    b1.cur_rdata <= cur_mem[b1.cur_addr];
    b1.org_rdata <= org_mem[b1.org_addr];
    b3.cur_rdata <= cur_mem[b3.cur_addr];
    b3.org_rdata <= org_mem[b3.org_addr];
  end
  typedef struct {
    int step;
    logic [63:0] cur;
    logic [47:0] org;
  } vec_t;
  vec_t tbl [3];
  logic [63:0] obs_cur [9];
  logic [47:0] obs_org [9];
  logic [11:0] held_sad;
  logic [2:0] held_mvx, held_mvy;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic fill_order();
    for (int r = 0; r < 8; r++) begin
      cur_mem[r] = {8{8'(r)}};
      org_mem[r] = {6{8'(8'h80 + r)}};
    end
  endtask
  task automatic fill_rand();
    for (int r = 0; r < 8; r++) begin
      cur_mem[r] = {$urandom(), $urandom()};
      org_mem[r] = 48'({$urandom(), $urandom()});
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    held_sad = '0;
    held_mvx = '0;
    held_mvy = '0;
  endtask
  // Called at a negedge: start is high for this cycle (t); returns at the negedge of t+12.
  task automatic run1(input logic [11:0] s, input logic [2:0] x, input logic [2:0] y);
    b1.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      b1.start = k == 5;
      b1.sad_in = k == 12 ? s : 12'($urandom());
      b1.mvx_in = k == 12 ? x : 3'($urandom());
      b1.mvy_in = k == 12 ? y : 3'($urandom());
      chk($sformatf("busy k=%0d", k), 64'(b1.busy), 64'(k <= 11));
      chk($sformatf("result_valid k=%0d", k), 64'(b1.result_valid), 64'(k == 12));
      chk($sformatf("ready k=%0d", k), 64'(b1.ready), 64'(k >= 2 && k <= 10));
      chk($sformatf("sad_held k=%0d", k), 64'(b1.sad), 64'(held_sad));
      chk($sformatf("mv_held k=%0d", k), 64'({b1.mvx, b1.mvy}), 64'({held_mvx, held_mvy}));
      if (k >= 2 && k <= 10) begin
        obs_cur[k-2] = b1.cur_pix;
        obs_org[k-2] = b1.org_pix;
      end
    end
    b1.start = 1'b0;
    held_sad = s;
    held_mvx = x;
    held_mvy = y;
  endtask
  task automatic check_rows();
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("cur_pix step %0d", j), obs_cur[j], j < 8 ? cur_mem[j] : cur_mem[7]);
      if (j == 0) chk("org_pix step 0", 64'(obs_org[0]), 64'd0);
      else chk($sformatf("org_pix step %0d", j), 64'(obs_org[j]), 64'(org_mem[j-1]));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int busy_n;
    int rv_n;
    logic [11:0] sads [4];
    logic [2:0] mxs [4];
    logic [2:0] mys [4];
    logic [11:0] m_sad;
    logic [2:0] m_x, m_y;
    tbl[0] = '{0, 64'h0, 48'h0};
    tbl[1] = '{3, 64'h0303030303030303, 48'h828282828282};
    tbl[2] = '{8, 64'h0707070707070707, 48'h878787878787};
    b1.start = 1'b0; b1.sad_in = '0; b1.mvx_in = '0; b1.mvy_in = '0;
    b3.start = 1'b0; b3.sad_in = '0; b3.mvx_in = '0; b3.mvy_in = '0;
    fill_order();
    @(negedge clk);
    do_reset();
    chk("reset busy", 64'(b1.busy), 64'd0);
    chk("reset ready", 64'(b1.ready), 64'd0);
    chk("reset result_valid", 64'(b1.result_valid), 64'd0);
    chk("reset cur_pix", b1.cur_pix, 64'd0);
    chk("reset sad", 64'(b1.sad), 64'd0);
`ifdef FRAC_FEEDER_MINSAD_EN
    chk("reset min_sad", 64'(b1.min_sad), 64'hFFF);
`endif
    run1(12'h05A, 3'd3, 3'd5);
    for (int i = 0; i < 3; i++)
      chk($sformatf("table step %0d cur", tbl[i].step), obs_cur[tbl[i].step], tbl[i].cur);
    for (int i = 0; i < 3; i++)
      chk($sformatf("table step %0d org", tbl[i].step), 64'(obs_org[tbl[i].step]), 64'(tbl[i].org));
    check_rows();
    for (int b = 0; b < 6; b++) begin
      fill_rand();
      @(negedge clk);
      run1(12'($urandom()), 3'($urandom()), 3'($urandom()));
      check_rows();
    end
    @(negedge clk);
    chk("sad after chain", 64'(b1.sad), 64'(held_sad));
    chk("mv after chain", 64'({b1.mvx, b1.mvy}), 64'({held_mvx, held_mvy}));
    fill_order();
    @(negedge clk);
    b1.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b1.start = 1'b0;
    end
    chk("step 4 ready before reset", 64'(b1.ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    held_sad = '0; held_mvx = '0; held_mvy = '0;
    chk("midreset ready", 64'(b1.ready), 64'd0);
    chk("midreset busy", 64'(b1.busy), 64'd0);
    chk("midreset cur_pix", b1.cur_pix, 64'd0);
    chk("midreset org_pix", 64'(b1.org_pix), 64'd0);
    chk("midreset sad", 64'(b1.sad), 64'd0);
    chk("midreset addr", 64'({b1.cur_addr, b1.org_addr}), 64'd0);
    rv_n = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (b1.result_valid) rv_n++;
    end
    chk("midreset no result_valid", 64'(rv_n), 64'd0);
    run1(12'hABC, 3'd6, 3'd1);
    check_rows();
    @(negedge clk);
    b3.start = 1'b1;
    busy_n = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      b3.start = 1'b0;
      b3.sad_in = k == 14 ? 12'h123 : 12'($urandom());
      b3.mvx_in = k == 14 ? 3'd2 : 3'($urandom());
      b3.mvy_in = k == 14 ? 3'd7 : 3'($urandom());
      if (b3.busy) busy_n++;
      chk($sformatf("lat3 result_valid k=%0d", k), 64'(b3.result_valid), 64'(k == 14));
      if (k == 15) chk("lat3 capture", 64'({b3.sad, b3.mvx, b3.mvy}), 64'({12'h123, 3'd2, 3'd7}));
    end
    chk("lat3 busy cycles", 64'(busy_n), 64'd13);
`ifdef FRAC_FEEDER_MINSAD_EN
    do_reset();
    sads = '{12'd300, 12'd120, 12'd120, 12'd400};
    mxs = '{3'd1, 3'd3, 3'd5, 3'd7};
    mys = '{3'd2, 3'd4, 3'd6, 3'd7};
    m_sad = 12'hFFF; m_x = '0; m_y = '0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      run1(sads[b], mxs[b], mys[b]);
      if (sads[b] < m_sad) begin
        m_sad = sads[b]; m_x = mxs[b]; m_y = mys[b];
      end
    end
    @(negedge clk);
    chk("min_sad", 64'(b1.min_sad), 64'(m_sad));
    chk("min_mv", 64'({b1.min_mvx, b1.min_mvy}), 64'({m_x, m_y}));
`else
    sads = '{default: '0};
    mxs = '{default: '0};
    mys = '{default: '0};
    m_sad = '0; m_x = '0; m_y = '0;
`endif
    rv_n = 0;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b1.result_valid) rv_n++;
      if (b1.busy) busy_n++;
    end
    chk("idle tail result_valid", 64'(rv_n), 64'd0);
    chk("idle tail busy", 64'(busy_n), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
